// File: rtl/instr_mem_loader.sv
// Packs RV32I field tuples (R/I/S/B/U/J) into 32-bit words and writes them
// to instruction memory at sequential word addresses.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               restart loading at BASE_ADDR
//   in_valid/in_ready   tuple handshake
//   in_fmt..in_imm      instruction fields
//   in_last             tuple is the final instruction
//   mem_we/mem_ready    write request, held until accepted
//   mem_addr/mem_wdata  word address and encoded instruction
//   busy/done/err/count status

module instr_mem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_fmt,
  input  logic                  in_last,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] L_BASE =
    ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] L_TOP = '1;
  localparam logic [ADDR_WIDTH-1:0] L_ONE =
    ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0] L_CONE =
    (ADDR_WIDTH+1)'(1);

  state_t                r_state;
  state_t                w_state_nx;
  logic                  r_we;
  logic                  w_we_nx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nx;
  logic [31:0]           r_wdata;
  logic [31:0]           w_wdata_nx;
  logic                  r_last;
  logic                  w_last_nx;
  logic                  r_done;
  logic                  w_done_nx;
  logic                  r_err;
  logic                  w_err_nx;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   w_count_nx;

  logic                  w_legal;
  logic [31:0]           w_enc;
  logic                  w_load;
  logic                  w_final;
  logic                  w_ready;
  logic                  w_acc;
  logic                  w_wr;

  always_comb begin
    w_legal = 1'b1;
    w_enc   = '0;
    unique case (in_fmt)
      3'd0: w_enc = {in_funct7, in_rs2, in_rs1,
                     in_funct3, in_rd, in_opcode};
      3'd1: w_enc = {in_imm[11:0], in_rs1,
                     in_funct3, in_rd, in_opcode};
      3'd2: w_enc = {in_imm[11:5], in_rs2, in_rs1,
                     in_funct3, in_imm[4:0], in_opcode};
      3'd3: w_enc = {in_imm[12], in_imm[10:5],
                     in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
      3'd4: w_enc = {in_imm[31:12], in_rd, in_opcode};
      3'd5: w_enc = {in_imm[20], in_imm[10:1],
                     in_imm[11], in_imm[19:12],
                     in_rd, in_opcode};
      default: w_legal = 1'b0;
    endcase
  end

  assign w_load = (r_state == S_LOAD);

  // A word in flight that ends the program (last or top
  // address) must not be followed by another accept.
  assign w_final = r_we && (r_last || (r_addr == L_TOP));

  assign w_ready = w_load && (!r_we || mem_ready)
                   && !w_final;
  assign w_acc   = in_valid && w_ready && !start;
  assign w_wr    = r_we && mem_ready;

  always_comb begin
    w_state_nx = r_state;
    w_we_nx    = r_we;
    w_addr_nx  = r_addr;
    w_wdata_nx = r_wdata;
    w_last_nx  = r_last;
    w_done_nx  = r_done;
    w_err_nx   = r_err;
    w_count_nx = r_count;
    if (start) begin
      w_state_nx = S_LOAD;
      w_we_nx    = 1'b0;
      w_addr_nx  = L_BASE;
      w_last_nx  = 1'b0;
      w_done_nx  = 1'b0;
      w_err_nx   = 1'b0;
      w_count_nx = '0;
    end else if (w_load) begin
      if (w_wr) begin
        w_we_nx    = 1'b0;
        w_addr_nx  = r_addr + L_ONE;
        w_count_nx = r_count + L_CONE;
        if (r_addr == L_TOP) begin
          w_err_nx   = 1'b1;
          w_state_nx = S_DONE;
          w_done_nx  = 1'b1;
        end else if (r_last) begin
          w_state_nx = S_DONE;
          w_done_nx  = 1'b1;
        end
      end
      if (w_acc) begin
        if (w_legal) begin
          w_we_nx    = 1'b1;
          w_wdata_nx = w_enc;
          w_last_nx  = in_last;
        end else begin
          w_err_nx = 1'b1;
          if (in_last) begin
            w_state_nx = S_DONE;
            w_done_nx  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= L_BASE;
      r_wdata <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nx;
      r_we    <= w_we_nx;
      r_addr  <= w_addr_nx;
      r_wdata <= w_wdata_nx;
      r_last  <= w_last_nx;
      r_done  <= w_done_nx;
      r_err   <= w_err_nx;
      r_count <= w_count_nx;
    end
  end

  assign in_ready  = w_ready;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = w_load;
  assign done      = r_done;
  assign err       = r_err;
  assign count     = r_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed and random programs
// checked against a queue-based reference model.

module tb_instr_mem_loader;

  localparam int AW    = 3;
  localparam int BASE  = 0;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [2:0]  fmt;
    logic        last;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } tup_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = '0;
  logic          in_last = 1'b0;
  logic [6:0]    in_opcode = '0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm = '0;
  logic          mem_we;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   count;

  instr_mem_loader #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_fmt   (in_fmt),
    .in_last  (in_last),
    .in_opcode(in_opcode),
    .in_rd    (in_rd),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_funct3(in_funct3),
    .in_funct7(in_funct7),
    .in_imm   (in_imm),
    .mem_we   (mem_we),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .count    (count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  tup_t          prog[$];
  logic [AW+31:0] obs[$];
  logic [AW+31:0] exp_q[$];
  int            exp_acc;
  bit            exp_err;

  // memory side: log every completed write
  always @(posedge clk)
    if (rst_n && mem_we && mem_ready && !start)
      obs.push_back({mem_addr, mem_wdata});

  // a stalled write must keep address and data
  bit            p_hold = 1'b0;
  logic [AW-1:0] p_addr;
  logic [31:0]   p_data;

  always @(posedge clk) begin
    p_hold = rst_n && mem_we && !mem_ready && !start;
    p_addr = mem_addr;
    p_data = mem_wdata;
  end

  always @(negedge clk)
    if (rst_n && p_hold) begin
      chk("hold_addr", 64'(mem_addr), 64'(p_addr));
      chk("hold_data", 64'(mem_wdata), 64'(p_data));
    end

  function automatic logic [31:0] enc(input tup_t t);
    logic [31:0] op, rd, r1, r2, f3, f7, im;
    op = 32'(t.op);
    rd = 32'(t.rd);
    r1 = 32'(t.rs1);
    r2 = 32'(t.rs2);
    f3 = 32'(t.f3);
    f7 = 32'(t.f7);
    im = t.imm;
    case (t.fmt)
      3'd0: return (f7 << 25) | (r2 << 20) | (r1 << 15)
                   | (f3 << 12) | (rd << 7) | op;
      3'd1: return ((im & 32'hfff) << 20) | (r1 << 15)
                   | (f3 << 12) | (rd << 7) | op;
      3'd2: return (((im >> 5) & 32'h7f) << 25)
                   | (r2 << 20) | (r1 << 15) | (f3 << 12)
                   | ((im & 32'h1f) << 7) | op;
      3'd3: return (((im >> 12) & 1) << 31)
                   | (((im >> 5) & 32'h3f) << 25)
                   | (r2 << 20) | (r1 << 15) | (f3 << 12)
                   | (((im >> 1) & 32'hf) << 8)
                   | (((im >> 11) & 1) << 7) | op;
      3'd4: return (im & 32'hfffff000) | (rd << 7) | op;
      3'd5: return (((im >> 20) & 1) << 31)
                   | (((im >> 1) & 32'h3ff) << 21)
                   | (((im >> 11) & 1) << 20)
                   | (((im >> 12) & 32'hff) << 12)
                   | (rd << 7) | op;
      default: return 32'h0;
    endcase
  endfunction

  function automatic tup_t mk(input int fmt, input int op,
                              input int rd, input int rs1,
                              input int rs2, input int f3,
                              input int f7, input int imm,
                              input bit last);
    tup_t t;
    t.fmt  = 3'(fmt);
    t.op   = 7'(op);
    t.rd   = 5'(rd);
    t.rs1  = 5'(rs1);
    t.rs2  = 5'(rs2);
    t.f3   = 3'(f3);
    t.f7   = 7'(f7);
    t.imm  = 32'(imm);
    t.last = last;
    return t;
  endfunction

  function automatic tup_t rnd(input bit ill, input bit last);
    int f;
    f = ill ? 6 + int'($urandom % 2) : int'($urandom % 6);
    return mk(f, int'($urandom), int'($urandom),
              int'($urandom), int'($urandom),
              int'($urandom), int'($urandom),
              int'($urandom), last);
  endfunction

  // Program semantics: tuples are taken in order until the
  // last one or until the memory is full; illegal ones only
  // raise err.
  task automatic model();
    logic [AW-1:0] a;
    exp_q.delete();
    exp_acc = 0;
    exp_err = 1'b0;
    foreach (prog[k]) begin
      exp_acc++;
      if (prog[k].fmt > 3'd5) begin
        exp_err = 1'b1;
      end else begin
        a = AW'((BASE + exp_q.size()) % DEPTH);
        exp_q.push_back({a, enc(prog[k])});
        if (BASE + exp_q.size() == DEPTH) begin
          exp_err = 1'b1;
          break;
        end
      end
      if (prog[k].last) break;
    end
  endtask

  task automatic drive(input tup_t t);
    in_fmt    = t.fmt;
    in_last   = t.last;
    in_opcode = t.op;
    in_rd     = t.rd;
    in_rs1    = t.rs1;
    in_rs2    = t.rs2;
    in_funct3 = t.f3;
    in_funct7 = t.f7;
    in_imm    = t.imm;
  endtask

  task automatic do_start();
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    obs.delete();
  endtask

  task automatic run_prog(input int rdy_pct,
                          input int hold_n,
                          input int gap_pct,
                          output int acc_n,
                          output int n_cyc);
    int i = 0;
    int hold = 0;
    int cyc = 0;
    bit first = 1'b1;
    bit hold_on;
    acc_n = 0;
    while (i < prog.size() && cyc < 60) begin
      @(negedge clk);
      drive(prog[i]);
      in_valid = (gap_pct == 0) ||
                 (int'($urandom % 100) >= gap_pct);
      hold_on = (hold > 0);
      if (hold_on) begin
        mem_ready = 1'b0;
        hold--;
      end else begin
        mem_ready = int'($urandom % 100) < rdy_pct;
      end
      #1;
      if (hold_on && mem_we)
        chk("bp_rdy", 64'(in_ready), 64'(0));
      if (in_valid && in_ready) begin
        i++;
        acc_n++;
        if (first && hold_n > 0) hold = hold_n;
        first = 1'b0;
      end
      cyc++;
    end
    n_cyc = cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      mem_ready = int'($urandom % 100) < rdy_pct;
      cyc++;
    end while (!done && cyc < 100);
    chk("timeout", 64'(done), 64'(1));
  endtask

  task automatic verify(input string tag, input int acc_n);
    int n;
    model();
    n = exp_q.size();
    chk({tag, "_nwr"}, 64'(obs.size()), 64'(n));
    for (int k = 0; k < n && k < obs.size(); k++) begin
      chk({tag, "_addr"}, 64'(obs[k][AW+31:32]),
          64'(exp_q[k][AW+31:32]));
      chk({tag, "_data"}, 64'(obs[k][31:0]),
          64'(exp_q[k][31:0]));
    end
    chk({tag, "_acc"}, 64'(acc_n), 64'(exp_acc));
    chk({tag, "_cnt"}, 64'(count), 64'(n));
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_we"}, 64'(mem_we), 64'(0));
    chk({tag, "_maddr"}, 64'(mem_addr),
        64'((BASE + n) % DEPTH));
    in_valid = 1'b1;
    #1;
    chk({tag, "_rdy"}, 64'(in_ready), 64'(0));
    in_valid = 1'b0;
  endtask

  initial begin
    int acc_n;
    int n_cyc;
    int n;
    logic [31:0] w_exp [4];

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we", 64'(mem_we), 64'(0));
    chk("rst_addr", 64'(mem_addr), 64'(BASE));
    chk("rst_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_rdy", 64'(in_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_cnt", 64'(count), 64'(0));
    rst_n = 1'b1;

    // idle ignores tuples
    @(negedge clk);
    drive(mk(0, 'h33, 3, 1, 2, 0, 0, 0, 1'b1));
    in_valid = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("idle_rdy", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    chk("idle_we", 64'(mem_we), 64'(0));

    // add x3,x1,x2: one-cycle latency
    do_start();
    drive(mk(0, 'h33, 3, 1, 2, 0, 0, 0, 1'b1));
    in_valid = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("add_rdy", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    chk("add_we", 64'(mem_we), 64'(1));
    chk("add_addr", 64'(mem_addr), 64'(0));
    chk("add_data", 64'(mem_wdata), 64'h002081B3);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("add_done", 64'(done), 64'(1));
    chk("add_cnt", 64'(count), 64'(1));
    chk("add_we0", 64'(mem_we), 64'(0));

    // I/S/B/J stream, one word per cycle
    prog.delete();
    prog.push_back(mk(1, 'h13, 1, 0, 0, 0, 0, 5, 1'b0));
    prog.push_back(mk(2, 'h23, 0, 1, 2, 2, 0, 8, 1'b0));
    prog.push_back(mk(3, 'h63, 0, 1, 2, 0, 0, -4, 1'b0));
    prog.push_back(mk(5, 'h6F, 1, 0, 0, 0, 0, 8, 1'b1));
    w_exp[0] = 32'h00500093;
    w_exp[1] = 32'h0020A423;
    w_exp[2] = 32'hFE208EE3;
    w_exp[3] = 32'h008000EF;
    do_start();
    run_prog(100, 0, 0, acc_n, n_cyc);
    chk("strm_cyc", 64'(n_cyc), 64'(4));
    n = obs.size();
    for (int k = 0; k < 4 && k < n; k++)
      chk("strm_word", 64'(obs[k][31:0]), 64'(w_exp[k]));
    verify("strm", acc_n);

    // backpressure during a 2-word stream
    prog.delete();
    prog.push_back(rnd(1'b0, 1'b0));
    prog.push_back(rnd(1'b0, 1'b1));
    do_start();
    run_prog(100, 3, 0, acc_n, n_cyc);
    verify("bp", acc_n);

    // illegal fmt between two valid tuples
    prog.delete();
    prog.push_back(rnd(1'b0, 1'b0));
    prog.push_back(mk(7, 'h33, 1, 1, 1, 0, 0, 0, 1'b0));
    prog.push_back(rnd(1'b0, 1'b1));
    do_start();
    run_prog(100, 0, 0, acc_n, n_cyc);
    verify("ill", acc_n);

    // overflow: more tuples than memory words
    prog.delete();
    for (int k = 0; k < DEPTH + 1; k++)
      prog.push_back(rnd(1'b0, 1'b0));
    do_start();
    run_prog(100, 0, 0, acc_n, n_cyc);
    verify("ovf", acc_n);

    // start wins over a same-cycle handshake
    do_start();
    @(negedge clk);
    drive(rnd(1'b0, 1'b1));
    in_valid = 1'b1;
    mem_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("stpri_we", 64'(mem_we), 64'(0));
    chk("stpri_busy", 64'(busy), 64'(1));
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;

    // random programs
    for (int r = 0; r < 10; r++) begin
      int len;
      int ill;
      len = 1 + int'($urandom % 6);
      ill = int'($urandom % (len + 1));
      prog.delete();
      for (int k = 0; k < len; k++)
        prog.push_back(rnd(k == ill && k != len - 1,
                           k == len - 1));
      do_start();
      run_prog(30 + int'($urandom % 71), 0, 25,
               acc_n, n_cyc);
      verify("rnd", acc_n);
    end

    // async reset while a write is stalled
    do_start();
    @(negedge clk);
    drive(rnd(1'b0, 1'b1));
    in_valid = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rstw_we1", 64'(mem_we), 64'(1));
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rstw_we", 64'(mem_we), 64'(0));
    chk("rstw_busy", 64'(busy), 64'(0));
    chk("rstw_cnt", 64'(count), 64'(0));
    chk("rstw_addr", 64'(mem_addr), 64'(BASE));
    @(negedge clk);
    rst_n = 1'b1;
    prog.delete();
    prog.push_back(rnd(1'b0, 1'b1));
    do_start();
    run_prog(100, 0, 0, acc_n, n_cyc);
    verify("rstw", acc_n);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
